mux4_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one 4:1 selection path between four requesters. It arbitrates among request lines, drives the mux select, and captures the selected requester's word into an output register. The output register is then offered downstream with a valid/ready handshake. It sits in front of the mux datapath and is its only source of `select`.

---
 rtl/mux4_rr_scheduler.sv | 120 ++++++++++++
 tb/tb_mux4_rr_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_scheduler.sv
// Round-robin scheduler driving a shared 4:1 select path into a valid/ready output register.
// Served requesters are masked for one cycle via their registered grant pulse.
module mux4_rr_scheduler #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [3:0]            i_req,
    input  logic [4*DATA_W-1:0]   i_data_in,
    output logic [3:0]            o_gnt,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_W-1:0]     o_out_data,
    output logic [1:0]            o_out_src,
    output logic                  o_busy
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [3:0]          r_gnt;
    logic [1:0]          r_last;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_src;

    logic [3:0]          w_qreq;
    logic [7:0]          w_qreq_dbl;
    logic [2:0]          w_base;
    logic [3:0]          w_rot;
    logic [1:0]          w_off;
    logic [1:0]          w_win;
    logic [DATA_W-1:0]   w_mux;
    logic                w_any;
    logic                w_load;

    assign w_qreq     = i_req & ~r_gnt;
    assign w_any      = |w_qreq;
    // Rotate so bit 0 is the requester right after the last one served.
    assign w_qreq_dbl = {w_qreq, w_qreq};
    assign w_base     = {1'b0, r_last} + 3'd1;
    assign w_rot      = w_qreq_dbl[w_base +: 4];

    always_comb begin
        w_off = 2'd3;
        if (w_rot[0]) begin
            w_off = 2'd0;
        end else if (w_rot[1]) begin
            w_off = 2'd1;
        end else if (w_rot[2]) begin
            w_off = 2'd2;
        end
    end

    assign w_win = r_last + 2'd1 + w_off;

    always_comb begin
        w_mux = '0;
        unique case (w_win)
            2'd0: w_mux = i_data_in[0*DATA_W +: DATA_W];
            2'd1: w_mux = i_data_in[1*DATA_W +: DATA_W];
            2'd2: w_mux = i_data_in[2*DATA_W +: DATA_W];
            2'd3: w_mux = i_data_in[3*DATA_W +: DATA_W];
            default: w_mux = '0;
        endcase
    end

    assign w_load = w_any && ((r_state == StIdle) || i_out_ready);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_state_nxt = StSend;
                end
            end
            StSend: begin
                if (i_out_ready && !w_any) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        o_out_valid = (r_state == StSend);
        o_busy      = (r_state == StSend);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gnt  <= 4'b0000;
            r_last <= 2'd3;
            r_data <= '0;
            r_src  <= 2'd0;
        end else if (w_load) begin
            r_gnt  <= 4'b0001 << w_win;
            r_last <= w_win;
            r_data <= w_mux;
            r_src  <= w_win;
        end else begin
            r_gnt  <= 4'b0000;
        end
    end

    assign o_gnt      = r_gnt;
    assign o_out_data = r_data;
    assign o_out_src  = r_src;

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Scoreboard bench: a cycle model pushes expected outputs per edge; popped and compared after it.
module tb_mux4_rr_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  gnt;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        busy;

    mux4_rr_scheduler #(.DATA_W(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_data_in   (data_in),
        .o_gnt       (gnt),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_src   (out_src),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [3:0] g;
        logic [7:0] d;
        logic [1:0] s;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] acc_src_q[$];
    logic [7:0] acc_data_q[$];

    int n_vec;
    int n_err;

    // Reference model state
    logic       m_valid;
    logic [3:0] m_gnt;
    logic [7:0] m_data;
    logic [1:0] m_src;
    int         m_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_gnt   = 4'b0000;
        m_data  = 8'h00;
        m_src   = 2'd0;
        m_last  = 3;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy},      32'd0);
        check({tag, "_gnt"},   {28'd0, gnt},       32'd0);
        check({tag, "_data"},  {24'd0, out_data},  32'd0);
        check({tag, "_src"},   {30'd0, out_src},   32'd0);
    endtask

    // Drive one cycle of stimulus, predict the post-edge outputs, then compare.
    task automatic cycle(input logic [3:0] r, input logic [31:0] d, input logic rdy);
        logic [3:0] qreq;
        bit         found;
        int         w;
        exp_t       e;
        exp_t       got;
        req       = r;
        data_in   = d;
        out_ready = rdy;
        qreq  = r & ~m_gnt;
        found = 1'b0;
        w     = 0;
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (m_last + k) % 4;
            if (!found && qreq[idx]) begin
                found = 1'b1;
                w     = idx;
            end
        end
        #1;
        if (out_valid && rdy) begin
            acc_src_q.push_back(out_src);
            acc_data_q.push_back(out_data);
        end
        if (found && (!m_valid || rdy)) begin
            m_valid = 1'b1;
            m_gnt   = 4'b0001 << w;
            m_data  = d[w*8 +: 8];
            m_src   = w[1:0];
            m_last  = w;
        end else begin
            m_gnt = 4'b0000;
            if (m_valid && rdy) m_valid = 1'b0;
        end
        e = '{v: m_valid, g: m_gnt, d: m_data, s: m_src};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            got = exp_q.pop_front();
            check("valid", {31'd0, out_valid}, {31'd0, got.v});
            check("busy",  {31'd0, busy},      {31'd0, got.v});
            check("gnt",   {28'd0, gnt},       {28'd0, got.g});
            check("data",  {24'd0, out_data},  {24'd0, got.d});
            check("src",   {30'd0, out_src},   {30'd0, got.s});
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req       = 4'b1111;
        data_in   = 32'h44332211;
        out_ready = 1'b1;
        #1;
        check_reset_outputs("rst_assert");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_reset_outputs("rst_hold");
        end
        model_reset();
        acc_src_q.delete();
        acc_data_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b1;
        req       = 4'b0000;
        data_in   = 32'h0;
        out_ready = 1'b0;
        model_reset();

        // Reset with all requests: first load must be requester 0.
        do_reset();
        cycle(4'b1111, 32'h44332211, 1'b0);
        check("rst_first_src", {30'd0, out_src}, 32'd0);
        check("rst_first_data", {24'd0, out_data}, 32'h11);

        // Single request on requester 2.
        do_reset();
        cycle(4'b0100, 32'h00A50000, 1'b1);
        check("single_gnt",  {28'd0, gnt},      32'h4);
        check("single_data", {24'd0, out_data}, 32'hA5);
        check("single_src",  {30'd0, out_src},  32'd2);
        cycle(4'b0000, 32'h00A50000, 1'b1);
        check("single_drop", {31'd0, out_valid}, 32'd0);

        // Round robin with wrap-around.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(4'b1111, 32'h13121110, 1'b1);
            check("rr_onehot", {31'd0, $onehot(gnt)}, 32'd1);
        end
        begin
            logic [1:0] exp_src [6];
            exp_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
            check("rr_count", (acc_src_q.size() >= 6) ? 32'd1 : 32'd0, 32'd1);
            for (int i = 0; i < 6 && acc_src_q.size() > 0; i++) begin
                logic [1:0] s;
                logic [7:0] dd;
                s  = acc_src_q.pop_front();
                dd = acc_data_q.pop_front();
                check("rr_src",  {30'd0, s},  {30'd0, exp_src[i]});
                check("rr_data", {24'd0, dd}, {24'd0, 8'h10 + {6'd0, exp_src[i]}});
            end
        end

        // Backpressure: hold requester 1's word while ready is low.
        do_reset();
        cycle(4'b0010, 32'h00003C00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1011, $urandom, 1'b0);
            check("bp_data", {24'd0, out_data}, 32'h3C);
            check("bp_src",  {30'd0, out_src},  32'd1);
            check("bp_gnt",  {28'd0, gnt},      32'd0);
        end
        cycle(4'b1011, 32'hD0C0B0A0, 1'b1);
        check("bp_next_src",  {30'd0, out_src},  32'd3);
        check("bp_next_data", {24'd0, out_data}, 32'hD0);

        // Single continuous requester: served every other cycle.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(4'b0001, 32'h000000E7, 1'b1);
            check("solo_gnt0", {31'd0, gnt[0]}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // Asynchronous reset while stalled in SEND.
        do_reset();
        cycle(4'b0110, 32'h00BBAA00, 1'b0);
        cycle(4'b0110, 32'h00BBAA00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        #1;
        rst_n = 1'b1;
        cycle(4'b1111, 32'h44332211, 1'b1);
        check("mid_rst_prio", {30'd0, out_src}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
